// File: rtl/kyber_butterfly_arbiter.sv
// kyber_butterfly_arbiter
// Round-robin arbiter that shares one butterfly/reduction unit (Barrett +
// Montgomery stage) between port 0 (NTT sequencer) and port 1 (INTT sequencer).
// A transaction walks IDLE -> ISSUE -> (WAIT) -> RETURN -> IDLE. The operands are
// latched when the request is granted. The results from the shared unit go back to
// the granted port unmodified.
// Optional WAIT watchdog: define BUTTERFLY_ARB_TIMEOUT_EN to add the timeout_err port.
module kyber_butterfly_arbiter #(
  parameter int COEFF_SZ       = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                r0_req,
  input  logic [COEFF_SZ-1:0] r0_zeta,
  input  logic [COEFF_SZ-1:0] r0_a,
  input  logic [COEFF_SZ-1:0] r0_b,
  output logic                r0_ack,
  output logic                r0_valid,
  output logic [COEFF_SZ-1:0] r0_out_a,
  output logic [COEFF_SZ-1:0] r0_out_b,
  input  logic                r1_req,
  input  logic [COEFF_SZ-1:0] r1_zeta,
  input  logic [COEFF_SZ-1:0] r1_a,
  input  logic [COEFF_SZ-1:0] r1_b,
  output logic                r1_ack,
  output logic                r1_valid,
  output logic [COEFF_SZ-1:0] r1_out_a,
  output logic [COEFF_SZ-1:0] r1_out_b,
  output logic                bf_ce,
  output logic [COEFF_SZ-1:0] bf_zeta,
  output logic [COEFF_SZ-1:0] bf_a,
  output logic [COEFF_SZ-1:0] bf_b,
  input  logic                bf_done,
  input  logic [COEFF_SZ-1:0] bf_out_a,
  input  logic [COEFF_SZ-1:0] bf_out_b,
`ifdef BUTTERFLY_ARB_TIMEOUT_EN
  output logic                timeout_err,
`endif
  output logic                grant_id,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RETURN
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                last_grant_q;
  logic                any_req;
  logic                pick;
  logic                capture;
  logic                timeout_hit;
  logic [COEFF_SZ-1:0] res_a;
  logic [COEFF_SZ-1:0] res_b;

  // Winner selection: a lone requester wins outright. In a tie the port that did not win last time gets the grant.
  always_comb begin
    any_req = r0_req | r1_req;
    pick    = (r0_req & r1_req) ? ~last_grant_q : r1_req;
  end

`ifdef BUTTERFLY_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] wait_cnt;

  // Watchdog hit on the last permitted WAIT cycle without a done strobe
  always_comb begin
    timeout_hit = (state_q == ST_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // WAIT cycle counter (zero whenever outside WAIT) and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_q != ST_WAIT) begin
        wait_cnt <= '0;
      end else if (!timeout_hit) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (timeout_hit && !bf_done) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  // Without the watchdog WAIT only ends on bf_done
  always_comb begin
    timeout_hit = 1'b0;
  end
`endif

  // Result capture: a done in ISSUE or WAIT ends the transaction. A timeout returns zeros.
  always_comb begin
    capture = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && (bf_done || timeout_hit);
    res_a   = bf_done ? bf_out_a : '0;
    res_b   = bf_done ? bf_out_b : '0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any_req) state_d = ST_ISSUE;
      ST_ISSUE:  state_d = bf_done ? ST_RETURN : ST_WAIT;
      ST_WAIT:   if (bf_done || timeout_hit) state_d = ST_RETURN;
      ST_RETURN: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Per-state strobes derived from the current state and owner
  always_comb begin
    bf_ce    = (state_q == ST_ISSUE);
    r0_ack   = (state_q == ST_ISSUE)  && !grant_id;
    r1_ack   = (state_q == ST_ISSUE)  &&  grant_id;
    r0_valid = (state_q == ST_RETURN) && !grant_id;
    r1_valid = (state_q == ST_RETURN) &&  grant_id;
    busy     = (state_q != ST_IDLE);
  end

  // Datapath: latch the winner's operands on grant and steer results to the owner
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      grant_id     <= 1'b0;
      bf_zeta      <= '0;
      bf_a         <= '0;
      bf_b         <= '0;
      r0_out_a     <= '0;
      r0_out_b     <= '0;
      r1_out_a     <= '0;
      r1_out_b     <= '0;
    end else begin
      if ((state_q == ST_IDLE) && any_req) begin
        grant_id     <= pick;
        last_grant_q <= pick;
        bf_zeta      <= pick ? r1_zeta : r0_zeta;
        bf_a         <= pick ? r1_a    : r0_a;
        bf_b         <= pick ? r1_b    : r0_b;
      end
      if (capture) begin
        if (grant_id) begin
          r1_out_a <= res_a;
          r1_out_b <= res_b;
        end else begin
          r0_out_a <= res_a;
          r0_out_b <= res_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_kyber_butterfly_arbiter.sv
// tb_kyber_butterfly_arbiter
// Directed bench for kyber_butterfly_arbiter. A driver process models both
// requesters and the shared unit. The shared unit returns a+b and a^zeta.
// Expected results are pushed into a scoreboard when a request is acknowledged.
// A monitor process pops the scoreboard on every rN_valid pulse.
// Define BUTTERFLY_ARB_TIMEOUT_EN to build the watchdog scenario as well.
`timescale 1ns/1ps
module tb_kyber_butterfly_arbiter;

  localparam int COEFF_SZ       = 16;
  localparam int TIMEOUT_CYCLES = 64;

  typedef struct {
    logic [15:0] zeta;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } job_t;

  typedef struct {
    int          port;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  logic                clk   = 1'b0;
  logic                reset = 1'b1;
  logic                req  [2] = '{1'b0, 1'b0};
  logic [COEFF_SZ-1:0] zeta [2] = '{16'd0, 16'd0};
  logic [COEFF_SZ-1:0] opa  [2] = '{16'd0, 16'd0};
  logic [COEFF_SZ-1:0] opb  [2] = '{16'd0, 16'd0};
  logic                r0_ack, r1_ack, r0_valid, r1_valid;
  logic [COEFF_SZ-1:0] r0_out_a, r0_out_b, r1_out_a, r1_out_b;
  logic                bf_ce;
  logic [COEFF_SZ-1:0] bf_zeta, bf_a, bf_b;
  logic                bf_done = 1'b0;
  logic [COEFF_SZ-1:0] bf_out_a = '0;
  logic [COEFF_SZ-1:0] bf_out_b = '0;
  logic                grant_id, busy;
`ifdef BUTTERFLY_ARB_TIMEOUT_EN
  logic                timeout_err;
`endif

  int   checks = 0;
  int   errors = 0;
  int   unit_lat = 3;
  int   spur_cnt = 0;
  bit   gap_check = 1'b0;
  job_t jobs [2][$];
  exp_t sb [$];
  int   grant_log [$];
  int   ack_count [2] = '{0, 0};
  int   last_ack_wait [2] = '{0, 0};
  bit   active [2] = '{1'b0, 1'b0};

  kyber_butterfly_arbiter #(.COEFF_SZ(COEFF_SZ), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .r0_req(req[0]), .r0_zeta(zeta[0]), .r0_a(opa[0]), .r0_b(opb[0]),
    .r0_ack(r0_ack), .r0_valid(r0_valid), .r0_out_a(r0_out_a), .r0_out_b(r0_out_b),
    .r1_req(req[1]), .r1_zeta(zeta[1]), .r1_a(opa[1]), .r1_b(opb[1]),
    .r1_ack(r1_ack), .r1_valid(r1_valid), .r1_out_a(r1_out_a), .r1_out_b(r1_out_b),
    .bf_ce(bf_ce), .bf_zeta(bf_zeta), .bf_a(bf_a), .bf_b(bf_b),
    .bf_done(bf_done), .bf_out_a(bf_out_a), .bf_out_b(bf_out_b),
`ifdef BUTTERFLY_ARB_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Queue one request for a port with its hand-computed expected result
  task automatic applyStimulus(input int port, input logic [15:0] z, input logic [15:0] a_in,
                               input logic [15:0] b_in, input logic [15:0] ea, input logic [15:0] eb);
    job_t j;
    j.zeta = z; j.a = a_in; j.b = b_in; j.exp_a = ea; j.exp_b = eb;
    jobs[port].push_back(j);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    tick();
    while (!(jobs[0].size() == 0 && jobs[1].size() == 0 && !active[0] && !active[1] &&
             sb.size() == 0 && !busy) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) checkOutput("drain_timeout", 32'd1, 32'd0);
    tick();
  endtask

  task automatic checkResetState();
    @(negedge clk);
    checkOutput("rst_r0_ack", r0_ack, 0);     checkOutput("rst_r1_ack", r1_ack, 0);
    checkOutput("rst_r0_valid", r0_valid, 0); checkOutput("rst_r1_valid", r1_valid, 0);
    checkOutput("rst_r0_out_a", r0_out_a, 0); checkOutput("rst_r0_out_b", r0_out_b, 0);
    checkOutput("rst_r1_out_a", r1_out_a, 0); checkOutput("rst_r1_out_b", r1_out_b, 0);
    checkOutput("rst_bf_ce", bf_ce, 0);       checkOutput("rst_bf_zeta", bf_zeta, 0);
    checkOutput("rst_bf_a", bf_a, 0);         checkOutput("rst_bf_b", bf_b, 0);
    checkOutput("rst_grant_id", grant_id, 0); checkOutput("rst_busy", busy, 0);
  endtask

  task automatic doReset(input int n);
    tick();
    reset = 1'b1;
    repeat (n) tick();
    checkResetState();
    tick();
    reset = 1'b0;
  endtask

  // Driver: shared-unit model plus both requesters, acting just after each rising edge
  initial begin : driver
    bit          pend;
    int          cd;
    int          spur_seen;
    int          wait_cnt [2];
    job_t        cur [2];
    logic        ackp;
    logic [15:0] ua, ub;
    pend = 1'b0; cd = 0; spur_seen = 0; ua = '0; ub = '0;
    wait_cnt = '{0, 0};
    forever begin
      @(posedge clk);
      #1;
      bf_done = 1'b0;
      if (reset) begin
        pend = 1'b0;
      end else if (bf_ce && unit_lat > 0) begin
        pend = 1'b1;
        cd   = unit_lat - 1;
        ua   = bf_a + bf_b;
        ub   = bf_a ^ bf_zeta;
      end else if (pend) begin
        cd--;
      end
      if (pend && cd == 0) begin
        bf_done = 1'b1; bf_out_a = ua; bf_out_b = ub; pend = 1'b0;
      end
      if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        bf_done = 1'b1; bf_out_a = 16'hDEAD; bf_out_b = 16'hBEEF;
      end
      for (int p = 0; p < 2; p++) begin
        ackp = (p == 1) ? r1_ack : r0_ack;
        if (active[p] && ackp) begin
          checkOutput("ack_bf_zeta", bf_zeta, cur[p].zeta);
          checkOutput("ack_bf_a", bf_a, cur[p].a);
          checkOutput("ack_bf_b", bf_b, cur[p].b);
          checkOutput("ack_grant_id", grant_id, p);
          sb.push_back('{p, cur[p].exp_a, cur[p].exp_b});
          last_ack_wait[p] = wait_cnt[p];
          ack_count[p]++;
          active[p] = 1'b0;
          req[p]    = 1'b0;
        end else if (active[p]) begin
          wait_cnt[p]++;
          if (wait_cnt[p] > 300) begin
            checkOutput("ack_timeout", 32'd1, 32'd0);
            active[p] = 1'b0;
            req[p]    = 1'b0;
          end
        end
        if (!active[p] && jobs[p].size() > 0 && !reset) begin
          cur[p]      = jobs[p].pop_front();
          active[p]   = 1'b1;
          wait_cnt[p] = 0;
          req[p]      = 1'b1;
          zeta[p]     = cur[p].zeta;
          opa[p]      = cur[p].a;
          opb[p]      = cur[p].b;
        end
      end
    end
  end

  // Monitor: scoreboard pop on each valid, plus timing and ownership checks at negedge
  initial begin : monitor
    int          cyc, ce_cyc, last_valid_cyc, p;
    bit          valid_in_window;
    logic [15:0] hold_a [2];
    logic [15:0] hold_b [2];
    exp_t        e;
    cyc = 0; ce_cyc = 0; last_valid_cyc = 0; valid_in_window = 1'b0;
    hold_a = '{16'd0, 16'd0};
    hold_b = '{16'd0, 16'd0};
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        sb.delete();
        hold_a = '{16'd0, 16'd0};
        hold_b = '{16'd0, 16'd0};
      end else begin
        if (bf_ce) begin
          ce_cyc = cyc;
          grant_log.push_back(int'(grant_id));
          if (gap_check && valid_in_window) checkOutput("issue_gap", cyc - last_valid_cyc, 2);
        end
        if (bf_ce || r0_ack || r1_ack)
          checkOutput("ack_vs_grant", {30'd0, r1_ack, r0_ack}, bf_ce ? (grant_id ? 2 : 1) : 0);
        if (r0_valid || r1_valid) begin
          checkOutput("valid_onehot", r0_valid & r1_valid, 0);
          p = r1_valid ? 1 : 0;
          checkOutput("valid_latency", cyc - ce_cyc, (unit_lat > 0) ? unit_lat : TIMEOUT_CYCLES + 1);
          if (sb.size() == 0) begin
            checkOutput("unexpected_valid", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            checkOutput("valid_port", p, e.port);
            checkOutput("out_a", (p == 1) ? r1_out_a : r0_out_a, e.a);
            checkOutput("out_b", (p == 1) ? r1_out_b : r0_out_b, e.b);
            hold_a[p] = e.a;
            hold_b[p] = e.b;
          end
          checkOutput("other_out_a", (p == 1) ? r0_out_a : r1_out_a, hold_a[1-p]);
          checkOutput("other_out_b", (p == 1) ? r0_out_b : r1_out_b, hold_b[1-p]);
          last_valid_cyc  = cyc;
          valid_in_window = gap_check;
        end
        if (!gap_check) valid_in_window = 1'b0;
      end
    end
  end

  // Directed scenarios
  initial begin : stimulus
    int base, n, a0, a1;
    repeat (3) tick();
    checkResetState();
    tick();
    reset = 1'b0;

    // Single NTT request, unit latency 3
    applyStimulus(0, 16'd1701, 16'd5, 16'd7, 16'd12, 16'd1696);
    waitIdle(100);
    checkOutput("t1_ack_latency", last_ack_wait[0], 0);
    checkOutput("t1_ack_count", ack_count[0], 1);
    checkOutput("t1_r1_out_a", r1_out_a, 0);
    checkOutput("t1_r1_out_b", r1_out_b, 0);

    // Both ports held after reset: strict alternation starting with port 0
    doReset(2);
    base = grant_log.size();
    a0 = ack_count[0]; a1 = ack_count[1];
    applyStimulus(0, 16'd17, 16'd100, 16'd200, 16'd300, 16'd117);
    applyStimulus(1, 16'd1, 16'hFFFF, 16'd2, 16'h0001, 16'hFFFE);
    applyStimulus(0, 16'h00FF, 16'h1234, 16'h1111, 16'h2345, 16'h12CB);
    applyStimulus(1, 16'h8000, 16'h0F0F, 16'h00F0, 16'h0FFF, 16'h8F0F);
    waitIdle(200);
    checkOutput("t2_grant_count", grant_log.size() - base, 4);
    if (grant_log.size() >= base + 4)
      for (int i = 0; i < 4; i++) checkOutput("t2_grant_order", grant_log[base+i], i % 2);
    checkOutput("t2_r0_acks", ack_count[0] - a0, 2);
    checkOutput("t2_r1_acks", ack_count[1] - a1, 2);

    // Port 1 alone, back-to-back: one IDLE cycle between RETURN and ISSUE
    gap_check = 1'b1;
    applyStimulus(1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd3);
    applyStimulus(1, 16'd0, 16'd10, 16'd20, 16'd30, 16'd10);
    applyStimulus(1, 16'hAAAA, 16'h5555, 16'h0001, 16'h5556, 16'hFFFF);
    applyStimulus(1, 16'd3, 16'h7FFF, 16'h7FFF, 16'hFFFE, 16'h7FFC);
    waitIdle(200);
    gap_check = 1'b0;

    // Latency-1 unit, then a spurious done while idle
    unit_lat = 1;
    applyStimulus(0, 16'h0002, 16'h0040, 16'h0004, 16'h0044, 16'h0042);
    waitIdle(100);
    spur_cnt++;
    repeat (3) begin
      @(negedge clk);
      checkOutput("t4_busy_after_spurious", busy, 0);
    end
    tick();
    unit_lat = 3;

    // Reset during WAIT, then a late done
    unit_lat = 0;
    base = ack_count[0];
    applyStimulus(0, 16'd9, 16'd8, 16'd7, 16'd0, 16'd0);
    n = 0;
    while (ack_count[0] == base && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) checkOutput("t5_issue_timeout", 32'd1, 32'd0);
    repeat (3) tick();
    @(negedge clk);
    checkOutput("t5_busy_in_wait", busy, 1);
    doReset(2);
    tick();
    spur_cnt++;
    repeat (3) tick();
    checkResetState();
    tick();
    unit_lat = 3;

`ifdef BUTTERFLY_ARB_TIMEOUT_EN
    // Unit never answers: watchdog returns zeros and sets the sticky flag
    checkOutput("t6_err_before", timeout_err, 0);
    unit_lat = 0;
    applyStimulus(0, 16'd9, 16'd9, 16'd9, 16'd0, 16'd0);
    waitIdle(200);
    checkOutput("t6_err_set", timeout_err, 1);
    unit_lat = 3;
    applyStimulus(1, 16'd4, 16'd1, 16'd1, 16'd2, 16'd5);
    waitIdle(100);
    checkOutput("t6_err_sticky", timeout_err, 1);
    doReset(2);
    @(negedge clk);
    checkOutput("t6_err_cleared", timeout_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin : watchdog
    #300000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
